// File: rtl/if_stage_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// Word and address widths, the NOP filler and the IF/ID bundle.
package if_stage_pkg;

  localparam int INST_WIDTH      = 32;
  localparam int INST_ADDR_WIDTH = 32;

  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef logic [INST_WIDTH-1:0]      inst_t;
  typedef logic [INST_ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    inst_t inst;
    addr_t addr;
  } if_id_t;

  function automatic addr_t word_align(addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory request/response bus.
// master = fetch unit, slave = instruction memory.
interface if_stage_if;
  import if_stage_pkg::*;

  logic  imem_req_o;
  addr_t imem_addr_o;
  logic  imem_gnt_i;
  logic  imem_rvalid_i;
  inst_t imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/if_stage_sync_fifo.sv
// Small synchronous FIFO: push, pop, clear, count, head.
// Clear wins over push/pop; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Storage write; contents need no reset, pointers guard validity.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// RV32I fetch stage: PC, credit-limited imem fetch, in-order buffer.
// Optional misaligned-redirect trap: define IFU_MISALIGN_TRAP_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter addr_t RESET_ADDR = 32'h0000_0000,
  parameter int    FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  if_stage_if.master imem,
  input  logic  redirect_i,
  input  addr_t redirect_addr_i,
  input  logic  stall_i,
  output logic  inst_valid_o,
  output inst_t inst_o,
  output addr_t inst_addr_o
`ifdef IFU_MISALIGN_TRAP_EN
  , output logic fetch_misalign_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = CW + 1;

  typedef logic [CW-1:0] cnt_t;

  addr_t  pc;
  addr_t  target;
  addr_t  aq_head;
  cnt_t   out_cnt;
  cnt_t   disc_cnt;
  cnt_t   fifo_cnt;
  if_id_t fifo_head;
  if_id_t fifo_din;
  logic   [IW-1:0] inflight;
  logic   halted;
  logic   pop;
  logic   grant;
  logic   push;
  logic   rvalid;

  assign rvalid = imem.imem_rvalid_i;

`ifdef IFU_MISALIGN_TRAP_EN
  assign target = redirect_addr_i;

  // A misaligned redirect parks the stage until an aligned one arrives.
  always_ff @(posedge clk) begin
    if (rst)
      halted <= 1'b0;
    else if (redirect_i)
      halted <= |redirect_addr_i[1:0];
  end

  assign fetch_misalign_o = halted;
`else
  assign target = word_align(redirect_addr_i);
  assign halted = 1'b0;
`endif

  assign inst_valid_o = (fifo_cnt != '0) && !halted;
  assign pop          = inst_valid_o && !stall_i;

  // Every granted fetch already owns a buffer slot, so the memory never
  // needs back-pressure on responses.
  assign inflight = {1'b0, out_cnt}
                  + {1'b0, fifo_cnt}
                  - IW'(pop);

  assign imem.imem_req_o  = !rst && !redirect_i && !halted
                         && (inflight < IW'(FIFO_DEPTH));
  assign imem.imem_addr_o = pc;
  assign grant = imem.imem_req_o && imem.imem_gnt_i;

  assign push = rvalid && (disc_cnt == '0) && !redirect_i;
  assign fifo_din = '{inst: imem.imem_rdata_i, addr: aq_head};

  // The address queue occupancy is exactly the outstanding count.
  sync_fifo #(
    .WIDTH(INST_ADDR_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_addr_q (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (grant),
    .pop   (rvalid),
    .din   (pc),
    .head  (aq_head),
    .count (out_cnt)
  );

  sync_fifo #(
    .WIDTH($bits(if_id_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_i),
    .push  (push),
    .pop   (pop && !redirect_i),
    .din   (fifo_din),
    .head  (fifo_head),
    .count (fifo_cnt)
  );

  // PC advance and stale-response accounting; redirect dominates.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_ADDR;
      disc_cnt <= '0;
    end else if (redirect_i) begin
      pc       <= target;
      disc_cnt <= out_cnt - cnt_t'(rvalid);
    end else begin
      if (grant)
        pc <= pc + addr_t'(4);
      if (rvalid && disc_cnt != '0)
        disc_cnt <= disc_cnt - cnt_t'(1);
    end
  end

  assign inst_o      = (fifo_cnt != '0) ? fifo_head.inst : NOP_INST;
  assign inst_addr_o = (fifo_cnt != '0) ? fifo_head.addr : '0;

endmodule
